ddr_operand_loader: RTL and testbench
=====================================

# ddr_operand_loader

Reads one operand from DDR and unpacks it into the accelerator's native `config_pkg` types. It issues a burst of beat-sized read requests, collects the in-order `ddr_data_t` responses, and assembles either a `vector_t` or a `ternary_matrix_t`. It sits between the DDR read port and the matmul datapath. It is the inverse of the host-side packing that serializes operands into DDR words.

## Interface
Parameters:
- `MaxOutstanding`, 4: maximum read requests in flight; range 1..15.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `start_i`  in  1  load command; accepted when `ready_o`=1
- `kind_i`  in  `load_kind_e`  `LOAD_VECTOR` or `LOAD_MATRIX`
- `base_addr_i`  in  `DdrAddressWidth`  byte address of beat 0
- `ready_o`  out  1  idle, can accept a command
- `req_valid_o`  out  1  read request valid
- `req_addr_o`  out  `DdrAddressWidth`  request byte address
- `req_ready_i`  in  1  DDR accepts the request
- `rsp_valid_i`  in  1  read data beat valid; no backpressure
- `rsp_data_i`  in  `ddr_data_t`  read data beat
- `vector_o`  out  `vector_t`  assembled vector
- `matrix_o`  out  `ternary_matrix_t`  assembled matrix
- `done_o`  out  1  one-cycle pulse, operand complete
- `error_o`  out  1  sticky illegal-ternary flag for the current load

## Operation
- Beat width `W` = `$bits(ddr_data_t)`.
- Number of beats N:
  - Vector: N = `BeatsPerVector` = ceil(D·`$bits(fixed_point_t)`/W).
  - Matrix: N = `BeatsPerMatrix` = ceil(D·D·2/W).
- Packing is little-endian:
  - Flattened element k occupies bits [k·E +: E] of the concatenated stream. E is the element width.
  - Beat 0 supplies the stream LSBs.
  - Matrix index k = i·D + j maps to `matrix_o[i][j]`.
  - Padding bits in the last beat are ignored.
- Address rules:
  - Request n uses address `base_addr_i` + n·(W/8).
  - The low log2(W/8) bits of the base are forced to 0.
- FSM states:
  - IDLE: `ready_o`=1. On `start_i`, latch kind and base, clear counters and `error_o`, and go to BUSY.
  - BUSY: issue requests while req_cnt < N and outstanding < `MaxOutstanding`. Capture beats on `rsp_valid_i`. When rsp_cnt reaches N, go to DONE.
  - DONE: assert `done_o` for one cycle, then return to IDLE.
- Counters:
  - outstanding = issued − received.
  - A request handshake and a response in the same cycle leave outstanding unchanged.
  - Counters are wide enough for max(N) and `MaxOutstanding`, with no wrap.
- `start_i` while not IDLE is ignored.
- `rsp_valid_i` in IDLE is ignored, and no state changes.
- Only the selected output is updated. The other output holds its previous value.
- Outputs hold until the next load completes. Partial data is never visible.

## Timing
- Reset values: `ready_o`=1, `req_valid_o`=0, `req_addr_o`=0, `vector_o`=0, `matrix_o`=0, `done_o`=0, `error_o`=0, FSM in IDLE.
- `req_valid_o` rises the cycle after the start is accepted. Request handshakes can occur back-to-back every cycle.
- Once `req_valid_o` is raised, it and `req_addr_o` are held stable until `req_ready_i` is seen.
- Captured beats are staged internally. `vector_o`/`matrix_o` update in the same cycle `done_o`=1, which is one cycle after the last beat is captured.
- `ready_o` returns to 1 the cycle after `done_o`.
- Minimum command-to-`done_o` latency with zero DDR latency is N+2 cycles.
- Reset asserted mid-load aborts immediately: all outputs return to reset values, and in-flight responses are the environment's responsibility.

## Configuration
- `DDR_LOADER_TERNARY_CHECK_EN` defined:
  - Each matrix element equal to 2'b10 (−2) sets `error_o`, which stays set until the next accepted start.
  - The illegal element is written as 0.
- `DDR_LOADER_TERNARY_CHECK_EN` undefined:
  - Raw 2-bit codes pass through unchanged.
  - `error_o` is tied to 0.

## Structure
- `config_pkg` additions:
  - `load_kind_e`
  - `BeatsPerVector`, `BeatsPerMatrix`
  - `MaxBeats` = max of the two
  - `DdrBeatBytes` = W/8
- One sub-module, `ddr_beat_shifter`: a `MaxBeats`×W shift register that shifts right by W on each captured beat, with a flush that aligns short (vector) loads. The top level holds the FSM, counters, request logic, unpacking and the ternary check.

## Test plan
Bench configuration: D=4, 16-bit `fixed_point_t`, 32-bit `ddr_data_t`, so a vector is 2 beats and a matrix is 1 beat.

- Vector load, base 0x100, `req_ready_i`=1, responses 0x0002_0001 then 0x0004_0003 -> addresses 0x100 then 0x104; `vector_o`={1,2,3,4} with index 0 first; one `done_o` pulse.
- Matrix load, response 0x5555_5555 -> every `matrix_o[i][j]`=1; `error_o`=0.
- With `DDR_LOADER_TERNARY_CHECK_EN`, response with the bit [1:0] element = 2'b10 -> `matrix_o[0][0]`=0 and `error_o`=1. A new start clears `error_o`.
- `MaxOutstanding`=1, `req_ready_i` stalled 3 cycles -> `req_addr_o` held stable; the second request is not issued until the first response arrives.
- `start_i` held during BUSY, plus a stray `rsp_valid_i` while IDLE -> exactly one load runs; outputs are unchanged by the stray beat.
- `rst_ni` pulsed low after the first vector beat -> all outputs at reset values; the next load completes correctly.

Source files
------------

// File: rtl/config_pkg.sv
// Shared accelerator types and DDR operand loader geometry.
// Ternary element checking is enabled by DDR_LOADER_TERNARY_CHECK_EN.
package config_pkg;

    localparam int D               = 4;
    localparam int DdrAddressWidth = 32;

    typedef logic signed [15:0] fixed_point_t;
    typedef logic [31:0]        ddr_data_t;
    typedef logic [1:0]         ternary_t;

    typedef fixed_point_t [D-1:0]    vector_t;
    typedef ternary_t [D-1:0][D-1:0] ternary_matrix_t;

    typedef enum logic {
        LOAD_VECTOR = 1'b0,
        LOAD_MATRIX = 1'b1
    } load_kind_e;

    localparam int BeatW      = $bits(ddr_data_t);
    localparam int VectorBits = D * $bits(fixed_point_t);
    localparam int MatrixBits = D * D * 2;

    localparam int BeatsPerVector = (VectorBits + BeatW - 1) / BeatW;
    localparam int BeatsPerMatrix = (MatrixBits + BeatW - 1) / BeatW;
    localparam int MaxBeats       = (BeatsPerVector > BeatsPerMatrix) ?
                                    BeatsPerVector : BeatsPerMatrix;
    localparam int DdrBeatBytes   = BeatW / 8;

endpackage

// File: rtl/ddr_beat_shifter.sv
// Beat staging register: new beats enter at the top and shift down.
// The aligned view drops pad beats so short loads sit at bit 0.
module ddr_beat_shifter #(
    parameter int Depth = 2,
    parameter int W     = 32,
    parameter int CntW  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 shift_i,
    input  logic [W-1:0]         beat_i,
    input  logic [CntW-1:0]      pad_i,
    output logic [Depth*W-1:0]   aligned_o
);

    logic [Depth*W-1:0]     sreg_q;
    logic [Depth*W-1:0]     sreg_d;
    logic [(Depth+1)*W-1:0] joined;

    always_comb begin
        joined = {beat_i, sreg_q};
        sreg_d = sreg_q;
        if (shift_i) begin
            sreg_d = joined[(Depth+1)*W-1:W];
        end
    end

    // View includes the beat arriving this cycle
    always_comb begin
        aligned_o = sreg_d;
        for (int k = 0; k < Depth; k++) begin
            if (CntW'(k) < pad_i) begin
                aligned_o = aligned_o >> W;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/ddr_operand_loader.sv
// Loads one vector or ternary matrix operand from DDR beats.
// Optional DDR_LOADER_TERNARY_CHECK_EN zeroes and flags 2'b10 elements.
module ddr_operand_loader
    import config_pkg::*;
#(
    parameter int MaxOutstanding = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  load_kind_e                 kind_i,
    input  logic [DdrAddressWidth-1:0] base_addr_i,
    output logic                       ready_o,
    output logic                       req_valid_o,
    output logic [DdrAddressWidth-1:0] req_addr_o,
    input  logic                       req_ready_i,
    input  logic                       rsp_valid_i,
    input  ddr_data_t                  rsp_data_i,
    output vector_t                    vector_o,
    output ternary_matrix_t            matrix_o,
    output logic                       done_o,
    output logic                       error_o
);

    localparam int CntMax = (MaxBeats > MaxOutstanding) ?
                            MaxBeats : MaxOutstanding;
    localparam int CntW   = $clog2(CntMax + 1);

    localparam logic [DdrAddressWidth-1:0] AddrMask =
        ~(DdrAddressWidth'(DdrBeatBytes - 1));
    localparam logic [CntW-1:0] PadV = CntW'(MaxBeats - BeatsPerVector);
    localparam logic [CntW-1:0] PadM = CntW'(MaxBeats - BeatsPerMatrix);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e     state_q, state_d;
    load_kind_e kind_q;

    logic [CntW-1:0] req_cnt_q, rsp_cnt_q, out_q;
    logic [CntW-1:0] req_cnt_d, out_d, nbeats, pad;
    logic            req_valid_q, req_valid_d;
    logic            accept, req_fire, rsp_fire, last_beat;

    logic [DdrAddressWidth-1:0] req_addr_q;
    logic [MaxBeats*BeatW-1:0]  aligned;

    vector_t         vector_q;
    ternary_matrix_t matrix_q, matrix_chk;

    assign accept    = (state_q == IDLE) && start_i;
    assign nbeats    = (kind_q == LOAD_VECTOR) ?
                       CntW'(BeatsPerVector) : CntW'(BeatsPerMatrix);
    assign pad       = (kind_q == LOAD_VECTOR) ? PadV : PadM;
    assign req_fire  = req_valid_q && req_ready_i;
    assign rsp_fire  = (state_q == BUSY) && rsp_valid_i &&
                       (rsp_cnt_q < nbeats);
    assign last_beat = rsp_fire && (rsp_cnt_q == nbeats - CntW'(1));

    assign req_cnt_d   = req_cnt_q + CntW'(req_fire);
    assign out_d       = out_q + CntW'(req_fire) - CntW'(rsp_fire);
    assign req_valid_d = (req_cnt_d < nbeats) &&
                         (out_d < CntW'(MaxOutstanding));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = BUSY;
            BUSY:    if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            kind_q      <= LOAD_VECTOR;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            out_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                kind_q      <= kind_i;
                req_cnt_q   <= '0;
                rsp_cnt_q   <= '0;
                out_q       <= '0;
                req_valid_q <= 1'b1;
                req_addr_q  <= base_addr_i & AddrMask;
            end else if (state_q == BUSY) begin
                req_cnt_q   <= req_cnt_d;
                rsp_cnt_q   <= rsp_cnt_q + CntW'(rsp_fire);
                out_q       <= out_d;
                req_valid_q <= req_valid_d;
                if (req_fire) begin
                    req_addr_q <= req_addr_q + DdrAddressWidth'(DdrBeatBytes);
                end
            end
        end
    end

    ddr_beat_shifter #(
        .Depth (MaxBeats),
        .W     (BeatW),
        .CntW  (CntW)
    ) u_shifter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .shift_i   (rsp_fire),
        .beat_i    (rsp_data_i),
        .pad_i     (pad),
        .aligned_o (aligned)
    );

`ifdef DDR_LOADER_TERNARY_CHECK_EN
    logic load_err;
    logic error_q;

    always_comb begin
        matrix_chk = ternary_matrix_t'(aligned[MatrixBits-1:0]);
        load_err   = 1'b0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                if (matrix_chk[i][j] == 2'b10) begin
                    matrix_chk[i][j] = 2'b00;
                    load_err         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (last_beat && (kind_q == LOAD_MATRIX)) begin
            error_q <= load_err;
        end
    end

    assign error_o = error_q;
`else
    always_comb begin
        matrix_chk = ternary_matrix_t'(aligned[MatrixBits-1:0]);
    end

    assign error_o = 1'b0;
`endif

    // Only the selected operand moves; the other keeps its last value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vector_q <= '0;
            matrix_q <= '0;
        end else if (last_beat) begin
            if (kind_q == LOAD_VECTOR) begin
                vector_q <= vector_t'(aligned[VectorBits-1:0]);
            end else begin
                matrix_q <= matrix_chk;
            end
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign done_o      = (state_q == DONE);
    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign vector_o    = vector_q;
    assign matrix_o    = matrix_q;

endmodule

// File: tb/tb_ddr_operand_loader.sv
// Scoreboard bench for ddr_operand_loader with a queued DDR responder.
// Build with DDR_LOADER_TERNARY_CHECK_EN to cover the ternary check.
module tb_ddr_operand_loader;
    import config_pkg::*;

    typedef struct packed {
        vector_t         vec;
        ternary_matrix_t mat;
        logic            err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    load_kind_e      kind = LOAD_VECTOR;
    logic [31:0]     base_addr = '0;
    logic            ready;
    logic            req_valid;
    logic [31:0]     req_addr;
    logic            req_ready = 1'b1;
    logic            rsp_valid;
    ddr_data_t       rsp_data;
    vector_t         vec_out;
    ternary_matrix_t mat_out;
    logic            done;
    logic            error;

    logic        rsp_en = 1'b1;
    logic        stray_en = 1'b0;
    logic [31:0] stray_data = '0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] hs_q[$];
    logic [31:0] addr_log[$];
    exp_t        sb[$];

    vector_t         model_vec = '0;
    ternary_matrix_t model_mat = '0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    ddr_operand_loader #(.MaxOutstanding(1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .kind_i      (kind),
        .base_addr_i (base_addr),
        .ready_o     (ready),
        .req_valid_o (req_valid),
        .req_addr_o  (req_addr),
        .req_ready_i (req_ready),
        .rsp_valid_i (rsp_valid),
        .rsp_data_i  (rsp_data),
        .vector_o    (vec_out),
        .matrix_o    (mat_out),
        .done_o      (done),
        .error_o     (error)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic exp_t model(load_kind_e k, logic [31:0] b);
        exp_t        e;
        logic [31:0] a;
        logic [63:0] s;
        logic [31:0] w;
        logic [1:0]  c;
        a     = b & ~32'h3;
        e.vec = model_vec;
        e.mat = model_mat;
        e.err = 1'b0;
        if (k == LOAD_VECTOR) begin
            s = {rd(a + 32'd4), rd(a)};
            for (int i = 0; i < 4; i++) e.vec[i] = s[16*i +: 16];
        end else begin
            w = rd(a);
            for (int n = 0; n < 16; n++) begin
                c = w[2*n +: 2];
`ifdef DDR_LOADER_TERNARY_CHECK_EN
                if (c == 2'b10) begin
                    c     = 2'b00;
                    e.err = 1'b1;
                end
`endif
                e.mat[n/4][n%4] = c;
            end
        end
        model_vec = e.vec;
        model_mat = e.mat;
        return e;
    endfunction

    // Request handshakes feed the responder and the address log
    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            hs_q.push_back(req_addr);
            addr_log.push_back(req_addr);
        end
    end

    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (stray_en) begin
                rsp_valid = 1'b1;
                rsp_data  = stray_data;
            end else if (rsp_en && hs_q.size() > 0) begin
                rsp_valid = 1'b1;
                rsp_data  = rd(hs_q.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("extra_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("vector", vec_out, e.vec);
                check("matrix", mat_out, e.mat);
                check("error", error, e.err);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(load_kind_e k, logic [31:0] b);
        check("ready_at_start", ready, 1);
        sb.push_back(model(k, b));
        kind      = k;
        base_addr = b;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
        tick(1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_req_addr"}, req_addr, 0);
        check({tag, "_vector"}, vec_out, 0);
        check({tag, "_matrix"}, mat_out, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        int          n;
        logic [31:0] a0;
        logic        exp_err;

        mem[32'h100] = 32'h0002_0001;
        mem[32'h104] = 32'h0004_0003;
        mem[32'h108] = 32'h7fff_8000;
        mem[32'h10c] = 32'h00ff_ff00;
        mem[32'h200] = 32'h5555_5555;
        mem[32'h300] = 32'h5555_5556;
        mem[32'h400] = 32'hcafe_0123;
        mem[32'h404] = 32'h4567_89ab;
        mem[32'h500] = 32'ha5a5_0f0f;
        mem[32'h700] = 32'h1111_2222;
        mem[32'h704] = 32'h3333_4444;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Basic vector load, aligned base
        addr_log.delete();
        d0 = done_cnt;
        start_load(LOAD_VECTOR, 32'h100);
        wait_done(40);
        check("vec_addr_cnt", addr_log.size(), 2);
        check("vec_addr0", addr_log[0], 32'h100);
        check("vec_addr1", addr_log[1], 32'h104);
        check("vec_elem0", vec_out[0], 16'd1);
        check("vec_elem3", vec_out[3], 16'd4);
        check("vec_done_pulses", done_cnt - d0, 1);
        check("vec_done_low", done, 0);
        check("vec_ready_back", ready, 1);

        // Unaligned base is forced down to a beat boundary
        addr_log.delete();
        start_load(LOAD_VECTOR, 32'h10b);
        wait_done(40);
        check("unal_addr_cnt", addr_log.size(), 2);
        check("unal_addr0", addr_log[0], 32'h108);
        check("unal_addr1", addr_log[1], 32'h10c);

        // Matrix of all +1
        start_load(LOAD_MATRIX, 32'h200);
        wait_done(40);
        check("mat_elem23", mat_out[2][3], 2'b01);
        check("mat_err", error, 0);

        // Illegal ternary code in element 0
        start_load(LOAD_MATRIX, 32'h300);
        wait_done(40);
`ifdef DDR_LOADER_TERNARY_CHECK_EN
        check("tern_elem00", mat_out[0][0], 2'b00);
        exp_err = 1'b1;
`else
        check("tern_elem00", mat_out[0][0], 2'b10);
        exp_err = 1'b0;
`endif
        tick(3);
        check("tern_err_sticky", error, exp_err);
        start_load(LOAD_VECTOR, 32'h100);
        check("tern_err_cleared", error, 0);
        wait_done(40);

        // Stalled request with a single outstanding slot
        addr_log.delete();
        req_ready = 1'b0;
        start_load(LOAD_VECTOR, 32'h400);
        check("stall_valid_rise", req_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_valid_hold", req_valid, 1);
            check("stall_addr_hold", req_addr, 32'h400);
        end
        rsp_en    = 1'b0;
        req_ready = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            check("stall_no_second_req", req_valid, 0);
            tick(1);
        end
        rsp_en = 1'b1;
        wait_done(40);
        check("stall_addr_cnt", addr_log.size(), 2);
        check("stall_addr1", addr_log[1], 32'h404);

        // Start held through the load, inputs changed while busy
        d0 = done_cnt;
        sb.push_back(model(LOAD_MATRIX, 32'h500));
        kind      = LOAD_MATRIX;
        base_addr = 32'h500;
        start     = 1'b1;
        tick(1);
        kind      = LOAD_VECTOR;
        base_addr = 32'h600;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("held_done_seen", done, 1);
        start = 1'b0;
        tick(10);
        check("held_one_load", done_cnt - d0, 1);
        check("held_sb_empty", sb.size(), 0);

        // Stray beat while idle
        d0 = done_cnt;
        stray_data = 32'hdead_beef;
        stray_en   = 1'b1;
        tick(1);
        stray_en   = 1'b0;
        tick(3);
        check("stray_vector", vec_out, model_vec);
        check("stray_matrix", mat_out, model_mat);
        check("stray_ready", ready, 1);
        check("stray_no_done", done_cnt - d0, 0);

        // Reset after the first vector beat
        d0 = done_cnt;
        start_load(LOAD_VECTOR, 32'h700);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            if (rsp_valid) break;
        end
        check("rst_beat_seen", rsp_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        hs_q.delete();
        model_vec = '0;
        model_mat = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("midrst_no_done", done_cnt - d0, 0);
        start_load(LOAD_VECTOR, 32'h700);
        wait_done(40);
        check("post_rst_elem0", vec_out[0], 16'h2222);
        check("post_rst_elem3", vec_out[3], 16'h3333);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
